// File: rtl/entropy_pkg.sv
// Shared state encoding, watchdog health codes and a saturating counter helper
// for the entropy scheduler.
package entropy_pkg;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    FAULT   = 2'd2
  } sched_state_t;

  localparam logic [7:0] HC_OK     = 8'h00;
  localparam logic [7:0] HC_RUNLEN = 8'h01;
  localparam logic [7:0] HC_BIAS   = 8'h02;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/entropy_scheduler_if.sv
// Bit-stream, request/grant and status bundle around the entropy scheduler.
// master drives bits, health and requests; slave is the scheduler side.
interface entropy_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 32
);
  import entropy_pkg::*;

  logic               entropy_bit;
  logic               health_valid;
  logic [7:0]         health_code;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               data_valid;
  logic [WORD_W-1:0]  data_out;
  sched_state_t       state;
  logic [7:0]         fault_code;
  logic [15:0]        fault_count;
  logic [15:0]        overrun_count;

  modport master (
    output entropy_bit, health_valid, health_code, req,
    input  grant, data_valid, data_out, state, fault_code, fault_count, overrun_count
  );

  modport slave (
    input  entropy_bit, health_valid, health_code, req,
    output grant, data_valid, data_out, state, fault_code, fault_count, overrun_count
  );

endinterface

// File: rtl/entropy_scheduler_rr_arbiter.sv
// Round-robin pick: first set req at or after ptr (mod N), one-hot winner.
// Purely combinational; zero latency, no backpressure of its own.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         winner
);
  localparam int PW = $clog2(N);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        winner[idx[PW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/entropy_scheduler.sv
// Discards a startup burst, packs health-checked bits MSB-first into words and hands each
// word to one requester; grant one cycle after hold fills; collection never stalls (overruns drop).
module entropy_scheduler
  import entropy_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WORD_W       = 32,
  parameter int STARTUP_BITS = 1024
) (
  input logic               clk,
  input logic               rst,
  entropy_scheduler_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STARTUP_BITS + 1);
  localparam int BW = $clog2(WORD_W);

  sched_state_t       st;
  logic [SW-1:0]      startup_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [WORD_W-2:0]  shift;
  logic [WORD_W-1:0]  hold;
  logic               hold_valid;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] winner;
  logic [NUM_REQ-1:0] grant_r;
  logic               data_valid_r;
  logic [WORD_W-1:0]  data_out_r;
  logic [7:0]         fault_code_r;
  logic [15:0]        fault_count_r;
  logic [15:0]        overrun_count_r;
  logic               word_done;
  logic [WORD_W-1:0]  word;
  logic               arb;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (winner)
  );

  assign word_done = (bit_cnt == BW'(WORD_W - 1));
  assign word      = {shift, bus.entropy_bit};
  assign arb       = hold_valid && (|bus.req);

  always_comb begin
    next_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) next_ptr = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st              <= STARTUP;
      startup_cnt     <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      hold            <= '0;
      hold_valid      <= 1'b0;
      ptr             <= '0;
      grant_r         <= '0;
      data_valid_r    <= 1'b0;
      data_out_r      <= '0;
      fault_code_r    <= '0;
      fault_count_r   <= '0;
      overrun_count_r <= '0;
    end else begin
      grant_r      <= '0;
      data_valid_r <= 1'b0;
      data_out_r   <= '0;
      if (!bus.health_valid) begin
        // Untrusted bit wins over everything: drop all partial and held entropy.
        st           <= FAULT;
        shift        <= '0;
        bit_cnt      <= '0;
        hold_valid   <= 1'b0;
        startup_cnt  <= '0;
        fault_code_r <= bus.health_code;
        if (st != FAULT) fault_count_r <= sat_inc16(fault_count_r);
      end else begin
        case (st)
          STARTUP: begin
            startup_cnt <= startup_cnt + 1'b1;
            if (startup_cnt == SW'(STARTUP_BITS - 1)) st <= RUN;
          end
          FAULT: begin
            st          <= STARTUP;
            startup_cnt <= '0;
          end
          RUN: begin
            shift   <= word[WORD_W-2:0];
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            if (arb) begin
              grant_r      <= winner;
              data_valid_r <= 1'b1;
              data_out_r   <= hold;
              ptr          <= next_ptr;
            end
            // A word landing while hold drains this cycle refills it directly.
            if (word_done) begin
              if (!hold_valid || arb) begin
                hold       <= word;
                hold_valid <= 1'b1;
              end else begin
                overrun_count_r <= sat_inc16(overrun_count_r);
              end
            end else if (arb) begin
              hold_valid <= 1'b0;
            end
          end
          default: st <= STARTUP;
        endcase
      end
    end
  end

  assign bus.grant         = grant_r;
  assign bus.data_valid    = data_valid_r;
  assign bus.data_out      = data_out_r;
  assign bus.state         = st;
  assign bus.fault_code    = fault_code_r;
  assign bus.fault_count   = fault_count_r;
  assign bus.overrun_count = overrun_count_r;

endmodule

// File: tb/tb_entropy_scheduler.sv
// Directed scoreboard bench for entropy_scheduler (4 requesters, 8-bit words, 16 startup bits).
module tb_entropy_scheduler;
  import entropy_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int WORD_W       = 8;
  localparam int STARTUP_BITS = 16;

  typedef struct packed {
    logic [31:0] at_edge;
    logic [3:0]  grant;
    logic [7:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  entropy_scheduler_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) bus ();

  entropy_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .WORD_W       (WORD_W),
    .STARTUP_BITS (STARTUP_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, want, edge_n);
    end
  endtask

  task automatic step(input logic b, input logic hv, input logic [7:0] hc, input logic [3:0] rq);
    bus.entropy_bit  = b;
    bus.health_valid = hv;
    bus.health_code  = hc;
    bus.req          = rq;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic startup(input int n, input logic [3:0] rq);
    for (int i = 0; i < n; i++) step(((edge_n + 1) % 2) == 1, 1'b1, HC_OK, rq);
  endtask

  task automatic send_word(input logic [7:0] w, input logic [3:0] rq0, input logic [3:0] rq);
    for (int i = 0; i < 8; i++) step(w[7-i], 1'b1, HC_OK, (i == 0) ? rq0 : rq);
  endtask

  task automatic push(input int at, input logic [3:0] g, input logic [7:0] d);
    sb.push_back('{at_edge: 32'(at), grant: g, data: d});
  endtask

  // Monitor: every delivered word must match the next expected grant, in order and on time.
  always @(negedge clk) begin
    if (!rst) begin
      check("valid_vs_grant", 32'(bus.data_valid), 32'(|bus.grant));
      if (bus.data_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: edge %0d grant %b data %h, expected no grant",
                   edge_n, bus.grant, bus.data_out);
        end else begin
          mon_e = sb.pop_front();
          check("grant_edge", 32'(edge_n), mon_e.at_edge);
          check("grant_onehot", 32'(bus.grant), 32'(mon_e.grant));
          check("grant_data", 32'(bus.data_out), 32'(mon_e.data));
        end
      end else begin
        check("idle_data_zero", 32'(bus.data_out), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.entropy_bit  = 1'b0;
    bus.health_valid = 1'b1;
    bus.health_code  = HC_OK;
    bus.req          = '0;
    #23;
    check("rst_state", 32'(bus.state), 32'(STARTUP));
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_fault_code", 32'(bus.fault_code), 32'd0);
    check("rst_fault_count", 32'(bus.fault_count), 32'd0);
    check("rst_overrun", 32'(bus.overrun_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;

    // Alternating stream from reset: first word 0xAA, granted at edge 25.
    startup(15, 4'b0001);
    check("startup_edge15_state", 32'(bus.state), 32'(STARTUP));
    startup(1, 4'b0001);
    check("startup_edge16_state", 32'(bus.state), 32'(RUN));
    push(25, 4'b0001, 8'hAA);
    send_word(8'hAA, 4'b0001, 4'b0001);

    // All requesters: rotation 0001 -> 0010 -> 0100 -> 1000 -> 0001 -> 0010.
    push(33, 4'b0010, 8'h11);
    send_word(8'h11, 4'b1111, 4'b1111);
    push(41, 4'b0100, 8'h22);
    send_word(8'h22, 4'b1111, 4'b1111);
    push(49, 4'b1000, 8'h33);
    send_word(8'h33, 4'b1111, 4'b1111);
    push(57, 4'b0001, 8'h44);
    send_word(8'h44, 4'b1111, 4'b1111);
    push(65, 4'b0010, 8'h55);
    send_word(8'h55, 4'b1111, 4'b1111);
    check("rotate_overrun", 32'(bus.overrun_count), 32'd0);

    // No requests for ~3 word periods: 0x66 held, 0x77 and 0x88 dropped.
    push(89, 4'b0100, 8'h66);
    send_word(8'h66, 4'b1111, 4'b0000);
    send_word(8'h77, 4'b0000, 4'b0000);
    send_word(8'h88, 4'b0000, 4'b0000);
    check("overrun_two", 32'(bus.overrun_count), 32'd2);
    send_word(8'h9A, 4'b0100, 4'b0100);

    // Bias fault mid-word with 0x9A held: the held word is never delivered.
    step(1'b1, 1'b1, HC_OK, 4'b0000);
    step(1'b0, 1'b1, HC_OK, 4'b0000);
    step(1'b1, 1'b1, HC_OK, 4'b0000);
    step(1'b0, 1'b0, HC_BIAS, 4'b0001);
    check("fault_state", 32'(bus.state), 32'(FAULT));
    check("fault_code_bias", 32'(bus.fault_code), 32'h02);
    check("fault_count_one", 32'(bus.fault_count), 32'd1);
    check("fault_no_valid", 32'(bus.data_valid), 32'd0);
    step(1'b1, 1'b1, HC_OK, 4'b0001);
    check("recover_state", 32'(bus.state), 32'(STARTUP));
    startup(15, 4'b0001);
    check("restart_edge116_state", 32'(bus.state), 32'(STARTUP));
    startup(1, 4'b0001);
    check("restart_edge117_state", 32'(bus.state), 32'(RUN));
    push(126, 4'b0001, 8'h3C);
    send_word(8'h3C, 4'b0001, 4'b0001);

    // Fault lands exactly on the edge 0x5A would be granted; two-cycle fault counts once.
    send_word(8'h5A, 4'b0001, 4'b0001);
    step(1'b0, 1'b0, HC_RUNLEN, 4'b0001);
    step(1'b1, 1'b0, HC_RUNLEN, 4'b0001);
    check("fault2_state", 32'(bus.state), 32'(FAULT));
    check("fault2_code", 32'(bus.fault_code), 32'h01);
    check("fault2_count", 32'(bus.fault_count), 32'd2);
    step(1'b1, 1'b1, HC_OK, 4'b0001);
    startup(16, 4'b0001);
    send_word(8'hC3, 4'b0001, 4'b0000);
    step(1'b0, 1'b1, HC_OK, 4'b0000);
    check("hold_full_state", 32'(bus.state), 32'(RUN));
    check("hold_full_overrun", 32'(bus.overrun_count), 32'd2);

    // Asynchronous reset mid-cycle with 0xC3 held: outputs clear at once, word lost.
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(bus.state), 32'(STARTUP));
    check("arst_grant", 32'(bus.grant), 32'd0);
    check("arst_valid", 32'(bus.data_valid), 32'd0);
    check("arst_data", 32'(bus.data_out), 32'd0);
    check("arst_fault_code", 32'(bus.fault_code), 32'd0);
    check("arst_fault_count", 32'(bus.fault_count), 32'd0);
    check("arst_overrun", 32'(bus.overrun_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;
    startup(16, 4'b0001);
    push(25, 4'b0001, 8'h0F);
    send_word(8'h0F, 4'b0001, 4'b0001);
    step(1'b0, 1'b1, HC_OK, 4'b0001);
    step(1'b1, 1'b1, HC_OK, 4'b0001);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
